// File: rtl/systolic_array_pkg.sv
// Shared op-code and FSM-state constants for the systolic array op decoder,
// plus the compute-phase length helper.
package systolic_array_pkg;

    typedef logic [2:0] op_code_t;
    typedef logic [2:0] state_t;

    localparam op_code_t OP_IDLE     = 3'b000;
    localparam op_code_t OP_WS_LOAD  = 3'b001;
    localparam op_code_t OP_WS_FLOW  = 3'b010;
    localparam op_code_t OP_OS_COMP  = 3'b011;
    localparam op_code_t OP_OS_DRAIN = 3'b100;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WS_LOAD  = 3'd1;
    localparam state_t ST_WS_FLOW  = 3'd2;
    localparam state_t ST_OS_CLR   = 3'd3;
    localparam state_t ST_OS_COMP  = 3'd4;
    localparam state_t ST_OS_DRAIN = 3'd5;

    // Cycles needed for the last operand to skew across the whole grid.
    function automatic int flow_len(input int rows, input int cols, input int k_depth);
        return k_depth + rows + cols - 2;
    endfunction

endpackage

// File: rtl/systolic_array_op_decoder_skew.sv
// Diagonal skew window: lane i is enabled while i <= cnt < i+K_DEPTH.
module skew_window_gen
    import systolic_array_pkg::*;
#(
    parameter int N       = 4,
    parameter int K_DEPTH = 4,
    parameter int CW      = 4
) (
    input  logic          active,
    input  logic [CW-1:0] cnt,
    output logic [N-1:0]  en
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            localparam int unsigned LO = gi;
            localparam int unsigned HI = gi + K_DEPTH;
            assign en[gi] = active && (32'(cnt) >= LO) && (32'(cnt) < HI);
        end
    endgenerate

endmodule

// File: rtl/systolic_array_op_decoder.sv
// Array-side op decoder: accepts one op per handshake and sequences the timed
// load / flow / clear / compute / drain phase enables for the PE grid.
module systolic_array_op_decoder
    import systolic_array_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      op_code_in,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic            op_abort,
    output logic            mode_os,
    output logic [ROWS-1:0] weight_load_en,
    output logic [ROWS-1:0] row_in_en,
    output logic [COLS-1:0] col_in_en,
    output logic            acc_clear,
    output logic            acc_en,
    output logic [COLS-1:0] drain_en,
    output logic            phase_done,
    output logic            err_illegal,
    output logic            busy
);

    localparam int F  = flow_len(ROWS, COLS, K_DEPTH);
    localparam int CW = $clog2(ROWS + COLS + K_DEPTH);

    localparam logic [CW-1:0] LOAD_LAST  = CW'(ROWS - 1);
    localparam logic [CW-1:0] FLOW_LAST  = CW'(F - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(COLS - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            w_loaded_reg, w_loaded_next;
    logic            os_pending_reg, os_pending_next;

    logic            mode_os_reg, mode_os_next;
    logic [ROWS-1:0] weight_load_reg, weight_load_next;
    logic [ROWS-1:0] row_in_reg, row_in_next;
    logic [COLS-1:0] col_in_reg, col_in_next;
    logic            acc_clear_reg, acc_clear_next;
    logic            acc_en_reg, acc_en_next;
    logic [COLS-1:0] drain_reg, drain_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic            row_active, col_active;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        w_loaded_next   = w_loaded_reg;
        os_pending_next = os_pending_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (op_valid) begin
                    case (op_code_in)
                        OP_IDLE: ;
                        OP_WS_LOAD: begin
                            state_next      = ST_WS_LOAD;
                            os_pending_next = 1'b0;
                        end
                        OP_WS_FLOW: begin
                            if (w_loaded_reg) state_next = ST_WS_FLOW;
                            else              err_next   = 1'b1;
                        end
                        OP_OS_COMP: begin
                            state_next    = ST_OS_CLR;
                            w_loaded_next = 1'b0;
                        end
                        OP_OS_DRAIN: begin
                            if (os_pending_reg) state_next = ST_OS_DRAIN;
                            else                err_next   = 1'b1;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            ST_WS_LOAD: begin
                if (cnt_reg == LOAD_LAST) begin
                    state_next    = ST_IDLE;
                    done_next     = 1'b1;
                    w_loaded_next = 1'b1;
                end
            end
            ST_WS_FLOW: begin
                if (cnt_reg == FLOW_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_OS_CLR: begin
                state_next = ST_OS_COMP;
                cnt_next   = '0;
            end
            ST_OS_COMP: begin
                if (cnt_reg == FLOW_LAST) begin
                    state_next      = ST_IDLE;
                    done_next       = 1'b1;
                    os_pending_next = 1'b1;
                end
            end
            ST_OS_DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next      = ST_IDLE;
                    done_next       = 1'b1;
                    os_pending_next = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // An aborted phase leaves no trace: no done pulse, no flag update.
        if (op_abort && (state_reg != ST_IDLE)) begin
            state_next      = ST_IDLE;
            done_next       = 1'b0;
            w_loaded_next   = w_loaded_reg;
            os_pending_next = os_pending_reg;
        end

        if (state_next == ST_IDLE) cnt_next = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        row_active       = (state_next == ST_WS_FLOW) || (state_next == ST_OS_COMP);
        col_active       = (state_next == ST_OS_COMP);
        mode_os_next     = (state_next == ST_OS_CLR) || (state_next == ST_OS_COMP) ||
                           (state_next == ST_OS_DRAIN);
        acc_clear_next   = (state_next == ST_OS_CLR);
        acc_en_next      = row_active;
        weight_load_next = (state_next == ST_WS_LOAD)  ? (ROWS'(1) << cnt_next) : '0;
        drain_next       = (state_next == ST_OS_DRAIN) ? (COLS'(1) << cnt_next) : '0;
    end

    skew_window_gen #(.N(ROWS), .K_DEPTH(K_DEPTH), .CW(CW)) u_row_skew (
        .active (row_active),
        .cnt    (cnt_next),
        .en     (row_in_next)
    );

    skew_window_gen #(.N(COLS), .K_DEPTH(K_DEPTH), .CW(CW)) u_col_skew (
        .active (col_active),
        .cnt    (cnt_next),
        .en     (col_in_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            w_loaded_reg    <= 1'b0;
            os_pending_reg  <= 1'b0;
            mode_os_reg     <= 1'b0;
            weight_load_reg <= '0;
            row_in_reg      <= '0;
            col_in_reg      <= '0;
            acc_clear_reg   <= 1'b0;
            acc_en_reg      <= 1'b0;
            drain_reg       <= '0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            w_loaded_reg    <= w_loaded_next;
            os_pending_reg  <= os_pending_next;
            mode_os_reg     <= mode_os_next;
            weight_load_reg <= weight_load_next;
            row_in_reg      <= row_in_next;
            col_in_reg      <= col_in_next;
            acc_clear_reg   <= acc_clear_next;
            acc_en_reg      <= acc_en_next;
            drain_reg       <= drain_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
        end
    end

    assign op_ready       = (state_reg == ST_IDLE);
    assign busy           = (state_reg != ST_IDLE);
    assign mode_os        = mode_os_reg;
    assign weight_load_en = weight_load_reg;
    assign row_in_en      = row_in_reg;
    assign col_in_en      = col_in_reg;
    assign acc_clear      = acc_clear_reg;
    assign acc_en         = acc_en_reg;
    assign drain_en       = drain_reg;
    assign phase_done     = done_reg;
    assign err_illegal    = err_reg;

endmodule

// File: tb/tb_systolic_array_op_decoder.sv
// Bench for systolic_array_op_decoder: directed vector table, a phase-timeline
// reference model under random ops, and an asynchronous mid-phase reset.
module tb_systolic_array_op_decoder;
    import systolic_array_pkg::*;

    localparam int R = 4;
    localparam int C = 4;
    localparam int K = 4;
    localparam int FL = K + R + C - 2;

    typedef struct packed {
        logic         mode;
        logic [R-1:0] wl;
        logic [R-1:0] row;
        logic [C-1:0] col;
        logic         clr;
        logic         acc;
        logic [C-1:0] drain;
        logic         done;
        logic         err;
        logic         busy;
        logic         ready;
    } out_t;

    typedef struct {
        logic       valid;
        logic [2:0] code;
        logic       abort;
        out_t       exp;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [2:0]   op_code_in;
    logic         op_valid;
    logic         op_ready;
    logic         op_abort;
    logic         mode_os;
    logic [R-1:0] weight_load_en;
    logic [R-1:0] row_in_en;
    logic [C-1:0] col_in_en;
    logic         acc_clear;
    logic         acc_en;
    logic [C-1:0] drain_en;
    logic         phase_done;
    logic         err_illegal;
    logic         busy;

    int vectors;
    int miscompares;

    systolic_array_op_decoder #(.ROWS(R), .COLS(C), .K_DEPTH(K)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_code_in     (op_code_in),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_abort       (op_abort),
        .mode_os        (mode_os),
        .weight_load_en (weight_load_en),
        .row_in_en      (row_in_en),
        .col_in_en      (col_in_en),
        .acc_clear      (acc_clear),
        .acc_en         (acc_en),
        .drain_en       (drain_en),
        .phase_done     (phase_done),
        .err_illegal    (err_illegal),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t dut_out;
    assign dut_out = {mode_os, weight_load_en, row_in_en, col_in_en, acc_clear, acc_en,
                      drain_en, phase_done, err_illegal, busy, op_ready};

    function automatic out_t mk(input logic mode, input logic [R-1:0] wl, input logic [R-1:0] row,
                                input logic [C-1:0] col, input logic clr, input logic acc,
                                input logic [C-1:0] drain, input logic done, input logic err,
                                input logic bsy);
        return {mode, wl, row, col, clr, acc, drain, done, err, bsy, ~bsy};
    endfunction

    out_t IDLE_O, DONE_O, ERR_O;

    task automatic check(input string name, input int idx, input out_t exp);
        vectors++;
        if (dut_out !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", name, idx, $time, dut_out, exp);
        end
    endtask

    // ---------------- timeline reference model ----------------
    out_t exp_q[$];
    out_t exp_cur;
    bit   m_w, m_os;
    int   pend;   // flag action applied when the phase's done cycle arrives

    function automatic logic [3:0] window(input int t, input int n);
        logic [3:0] w;
        w = '0;
        for (int i = 0; i < n; i++)
            if (t >= i && t < i + K) w[i] = 1'b1;
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_w = 0;
        m_os = 0;
        pend = 0;
        exp_cur = IDLE_O;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] code, input logic ab,
                              output out_t nxt);
        bit legal;
        nxt = IDLE_O;
        if (exp_cur.busy) begin
            if (ab) begin
                exp_q.delete();
                pend = 0;
            end else begin
                nxt = exp_q.pop_front();
                if (nxt.done) begin
                    if (pend == 1) m_w = 1;
                    if (pend == 2) m_os = 1;
                    if (pend == 3) m_os = 0;
                    pend = 0;
                end
            end
        end else if (v) begin
            legal = 1;
            case (code)
                OP_IDLE: legal = 1;
                OP_WS_LOAD: begin
                    m_os = 0;
                    pend = 1;
                    for (int i = 0; i < R; i++) exp_q.push_back(mk(0, 4'(1 << i), 0, 0, 0, 0, 0, 0, 0, 1));
                    exp_q.push_back(DONE_O);
                end
                OP_WS_FLOW: begin
                    if (!m_w) legal = 0;
                    else begin
                        for (int t = 0; t < FL; t++) exp_q.push_back(mk(0, 0, window(t, R), 0, 0, 1, 0, 0, 0, 1));
                        exp_q.push_back(DONE_O);
                    end
                end
                OP_OS_COMP: begin
                    m_w = 0;
                    pend = 2;
                    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
                    for (int t = 0; t < FL; t++) exp_q.push_back(mk(1, 0, window(t, R), window(t, C), 0, 1, 0, 0, 0, 1));
                    exp_q.push_back(DONE_O);
                end
                OP_OS_DRAIN: begin
                    if (!m_os) legal = 0;
                    else begin
                        pend = 3;
                        for (int i = 0; i < C; i++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 4'(1 << i), 0, 0, 1));
                        exp_q.push_back(DONE_O);
                    end
                end
                default: legal = 0;
            endcase
            if (!legal) nxt = ERR_O;
            else if (exp_q.size() > 0) nxt = exp_q.pop_front();
        end
    endtask

    task automatic step(input logic v, input logic [2:0] code, input logic ab);
        out_t nxt;
        check("model", 0, exp_cur);
        op_valid = v;
        op_code_in = code;
        op_abort = ab;
        model_edge(v, code, ab, nxt);
        @(posedge clk);
        #1;
        exp_cur = nxt;
        op_valid = 1'b0;
        op_abort = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("in_reset", 0, IDLE_O);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    // ---------------- directed table ----------------
    vec_t       tbl[$];
    logic [3:0] win[FL];
    logic [3:0] oh[4];

    task automatic add(input logic v, input logic [2:0] code, input logic ab, input out_t exp);
        vec_t e;
        e.valid = v;
        e.code = code;
        e.abort = ab;
        e.exp = exp;
        tbl.push_back(e);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        IDLE_O = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DONE_O = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        ERR_O  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        win = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        oh  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Each row: inputs driven in this cycle, outputs expected in this cycle.
        add(1, OP_WS_LOAD, 0, IDLE_O);
        for (int i = 0; i < 4; i++) add(0, OP_IDLE, 0, mk(0, oh[i], 0, 0, 0, 0, 0, 0, 0, 1));
        add(1, OP_WS_FLOW, 0, DONE_O);
        for (int t = 0; t < FL; t++) add(t == 3, OP_OS_DRAIN, 0, mk(0, 0, win[t], 0, 0, 1, 0, 0, 0, 1));
        add(1, OP_OS_COMP, 0, DONE_O);
        add(0, OP_IDLE, 0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        for (int t = 0; t < FL; t++) add(0, OP_IDLE, 0, mk(1, 0, win[t], win[t], 0, 1, 0, 0, 0, 1));
        add(1, OP_OS_DRAIN, 0, DONE_O);
        for (int i = 0; i < 4; i++) add(0, OP_IDLE, 0, mk(1, 0, 0, 0, 0, 0, oh[i], 0, 0, 1));
        add(1, OP_OS_DRAIN, 0, DONE_O);
        add(1, OP_WS_FLOW, 0, ERR_O);
        add(1, 3'b111, 0, ERR_O);
        add(1, OP_OS_COMP, 0, ERR_O);
        add(0, OP_IDLE, 0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        add(0, OP_IDLE, 0, mk(1, 0, win[0], win[0], 0, 1, 0, 0, 0, 1));
        add(0, OP_IDLE, 1, mk(1, 0, win[1], win[1], 0, 1, 0, 0, 0, 1));
        add(1, OP_OS_DRAIN, 0, IDLE_O);
        add(1, OP_IDLE, 0, ERR_O);
        add(1, OP_WS_LOAD, 1, IDLE_O);
        for (int i = 0; i < 4; i++) add(0, OP_IDLE, 0, mk(0, oh[i], 0, 0, 0, 0, 0, 0, 0, 1));
        add(0, OP_IDLE, 0, DONE_O);

        reset = 1'b0;
        op_valid = 1'b0;
        op_abort = 1'b0;
        op_code_in = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        do_reset();

        foreach (tbl[i]) begin
            check("table", i, tbl[i].exp);
            op_valid = tbl[i].valid;
            op_code_in = tbl[i].code;
            op_abort = tbl[i].abort;
            @(posedge clk);
            #1;
            op_valid = 1'b0;
            op_abort = 1'b0;
        end

        // Random ops against the timeline model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic       v;
            logic [2:0] code;
            logic       ab;
            v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 8) code = 3'($urandom_range(0, 4));
            else                          code = 3'($urandom_range(5, 7));
            ab = ($urandom_range(0, 29) == 0);
            step(v, code, ab);
        end

        // Asynchronous reset in the middle of a WS_FLOW phase.
        do_reset();
        step(1, OP_WS_LOAD, 0);
        repeat (4) step(0, OP_IDLE, 0);
        step(1, OP_WS_FLOW, 0);
        repeat (4) step(0, OP_IDLE, 0);
        check("flow_cycle5", 0, mk(0, 0, win[4], 0, 0, 1, 0, 0, 0, 1));
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset", 0, IDLE_O);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, OP_WS_FLOW, 0);
        check("flow_after_reset", 0, ERR_O);
        step(0, OP_IDLE, 0);
        check("idle_after_err", 0, IDLE_O);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_array_op_decoder.md
Name: systolic_array_op_decoder

Overview:
- Array-side receiver of the 3-bit operation code that systolic_array_fsm issues.
- Accepts one operation per valid/ready handshake, then sequences a timed phase. A phase drives per-row, per-column and per-accumulator enables into the PE grid, with diagonal skew.
- Returns phase_done to the FSM on completion and flags illegal or out-of-order operations.
- Covers both weight-stationary (WS) and output-stationary (OS) dataflows.

Parameters:
- ROWS, 4, PE rows.
- COLS, 4, PE columns.
- K_DEPTH, 4, operand vector length streamed per row/column in a compute phase.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- op_code_in  in  3  operation code from FSM
- op_valid  in  1  op_code_in is valid
- op_ready  out  1  decoder can accept an op (high only in IDLE)
- op_abort  in  1  synchronous abort of the running phase
- mode_os  out  1  1 = OS dataflow, 0 = WS dataflow
- weight_load_en  out  ROWS  one-hot row strobe for weight preload
- row_in_en  out  ROWS  skewed west-edge operand enables
- col_in_en  out  COLS  skewed north-edge operand enables
- acc_clear  out  1  clear PE accumulators (OS)
- acc_en  out  1  PE accumulate enable
- drain_en  out  COLS  one-hot column drain strobe
- phase_done  out  1  one-cycle pulse at phase end
- err_illegal  out  1  one-cycle pulse on rejected op
- busy  out  1  phase in progress

Behaviour:
- Op codes (package constants):
  - OP_IDLE=000
  - OP_WS_LOAD=001
  - OP_WS_FLOW=010
  - OP_OS_COMP=011
  - OP_OS_DRAIN=100
  - 101..111 reserved
- States: IDLE, WS_LOAD, WS_FLOW, OS_CLR, OS_COMP, OS_DRAIN.
- Internal: phase counter cnt, width $clog2(ROWS+COLS+K_DEPTH); flags w_loaded and os_pending.
- All outputs are registered, except op_ready = (state==IDLE).
- Accept: op_valid && op_ready at edge t. The new state is active from edge t+1, and first outputs are visible in the cycle after t. cnt resets to 0 on entry.
- OP_IDLE accepted: no-op, no done pulse.
- WS_LOAD:
  - Lasts ROWS cycles; weight_load_en = 1<<cnt.
  - On exit, w_loaded is set.
- WS_FLOW:
  - Lasts F = K_DEPTH+ROWS+COLS-2 cycles; mode_os=0; acc_en=1.
  - row_in_en[r] = (r <= cnt < r+K_DEPTH).
  - col_in_en = 0 (WS columns carry partial sums).
- OS_CLR: one cycle with acc_clear=1, mode_os=1, then OS_COMP.
- OS_COMP:
  - Lasts F cycles; mode_os=1; acc_en=1.
  - row_in_en[r] as in WS_FLOW; col_in_en[c] = (c <= cnt < c+K_DEPTH).
  - On exit, os_pending is set.
- OS_DRAIN:
  - Lasts COLS cycles; drain_en = 1<<cnt; mode_os=1.
  - On exit, os_pending is cleared.
- Phase end:
  - In the cycle after the last active cycle, all enables are 0, phase_done=1 and state=IDLE, so op_ready is high in that same cycle.
  - Back-to-back ops are permitted: accepting in the done cycle starts the next phase one cycle later.
- Rejections:
  - Cases: reserved code; WS_FLOW with w_loaded=0; OS_DRAIN with os_pending=0.
  - Response: err_illegal pulses in the cycle after acceptance, state stays IDLE, no phase_done, flags unchanged.
- Mode interactions:
  - Accepting OS_COMP clears w_loaded.
  - Accepting WS_LOAD clears os_pending.
- op_abort:
  - In any non-IDLE state, the next edge forces IDLE and zeroes all enables. No phase_done; flags are not updated by the aborted phase.
  - op_abort is ignored in IDLE.
  - If op_abort and op_valid occur in the same IDLE cycle, the op is accepted.
- Reset (asserted at any time, including mid-phase): asynchronously forces state=IDLE, cnt=0, flags=0, and every registered output to 0. op_ready=1 while in reset.
- busy = (state != IDLE).

Decomposition:
- Package systolic_array_pkg holds the op-code localparams, the state encoding and the F-length helper function.
- One sub-module, skew_window_gen, generates the N-wide window enable: bit i = (i <= cnt < i+K_DEPTH) when active.
  - Instantiated twice: ROWS wide for row_in_en and COLS wide for col_in_en.

Test Plan:
(All with ROWS=COLS=K_DEPTH=4, so F=10.)
- Reset, then WS_LOAD accepted at cycle 0:
  - weight_load_en = 0001, 0010, 0100, 1000 in cycles 1-4.
  - phase_done in cycle 5; op_ready=1 in cycle 5.
- WS_FLOW after load:
  - row_in_en[0] high in cycles 1-4; row_in_en[3] high in cycles 4-7.
  - acc_en high for cycles 1-10; phase_done in cycle 11.
- WS_FLOW straight after reset → err_illegal pulse in cycle 1, no phase_done, op_ready stays 1.
- OS_COMP then OS_DRAIN:
  - OS_COMP: acc_clear in cycle 1; col_in_en[3] high in cycles 5-8 (cycle 1 is OS_CLR, counting starts at cycle 2); phase_done in cycle 12.
  - OS_DRAIN accepted in cycle 12: drain_en one-hot in cycles 13-16, done in cycle 17.
  - A second OS_DRAIN → err_illegal.
- op_abort asserted in cycle 3 of OS_COMP → all enables 0 from cycle 4, no phase_done; a following OS_DRAIN → err_illegal.
- reset driven low mid WS_FLOW (cycle 5, between edges) → outputs 0 immediately; after release, op_ready=1 and WS_FLOW → err_illegal.
- Reserved code 3'b111 → err_illegal only.
